lfsr_count_decoder: RTL and testbench
=====================================

# lfsr_count_decoder

Readout decoder for the cascaded state-extension LFSR counter chain. It captures the raw per-stage 6-bit state {S[2:0],Q[2:0]} of all counter stages on request and converts each stage's code to a 3-bit binary digit, one stage per clock. It presents the concatenated binary count on a valid/ready output. It sits between the high-speed counter bank and the register/readout logic, in the same clock domain as the counters.

## Interface
- STAGES, 4: number of cascaded 3-bit counter stages; range 1..16.
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- snap_req  input  1  capture request pulse; accepted only in IDLE.
- Q_in  input  3*STAGES  LFSR bits; stage i occupies [3i+2:3i] as {Q2,Q1,Q0}.
- S_in  input  3*STAGES  extension bits; stage i occupies [3i+2:3i] as {S2,S1,S0}.
- busy  output  1  high in any state other than IDLE.
- count_out  output  3*STAGES  binary count; stage 0 is the LSB digit, bits [3i+2:3i] hold the digit for stage i.
- count_valid  output  1  count_out valid.
- rd_ready  input  1  consumer accepts count_out when high with count_valid.
- code_err  output  1  at least one stage held an illegal code (DECODE_ERR_EN only).
- err_stage  output  4  lowest stage index with an illegal code (DECODE_ERR_EN only).

## Operation
- Code table per stage, written as {S2,S1,S0,Q2,Q1,Q0} -> digit:
  - 000_111 -> 0
  - 100_011 -> 1
  - 000_110 -> 2
  - 100_001 -> 3
  - 000_010 -> 4
  - 000_100 -> 5
  - 110_101 -> 6
  - 101_111 -> 7, the terminal state.
  - Any other code is illegal.
- FSM states:
  - IDLE: if snap_req=1, load the capture registers from Q_in/S_in, clear index and error state, then go to DECODE.
  - DECODE: decode the captured stage[index] and write its digit to count_out[3*index+2:3*index]. Record an error if the code is illegal. Increment index. After stage STAGES-1, go to PRESENT.
  - PRESENT: count_valid=1. When rd_ready=1, go to IDLE.
- count_out holds its value after the handshake until the next decode overwrites it, digit by digit.
- snap_req outside IDLE is ignored. It is not queued.
- Reset values:
  - state IDLE
  - busy=0, count_valid=0
  - count_out all 0
  - code_err=0, err_stage=0
  - capture registers all 0
- Async Rst mid-decode or mid-PRESENT aborts immediately to the reset values. A partially decoded count is never presented.
- Index width is clog2(STAGES), minimum 1. Index never exceeds STAGES-1.

## Timing
- snap_req sampled high in IDLE at edge k: capture at edge k, busy=1 after edge k.
- Stage i digit is written at edge k+1+i.
- count_valid rises after edge k+STAGES.
- Latency from snap_req to count_valid is STAGES+1 cycles; STAGES=1 gives 2.
- In PRESENT, count_valid stays high and count_out stays stable until the edge where rd_ready=1. At that edge the FSM returns to IDLE and count_valid=0 after it.
- rd_ready high before count_valid has no effect.
- A snap_req in the same cycle as the handshake edge is ignored, because the FSM is not in IDLE at that edge. The earliest new capture is one cycle after the return to IDLE.
- The minimum snapshot period is STAGES+2 cycles.

## Configuration
- DECODE_ERR_EN defined:
  - An illegal code decodes to digit 0.
  - code_err is set and err_stage latches the first (lowest) offending index.
  - Both are valid with count_valid and are cleared at the next capture.
- DECODE_ERR_EN undefined:
  - An illegal code decodes to digit 0.
  - code_err and err_stage are tied to 0.
  - No error logic is synthesized.

## Test plan
- Reset sequence, STAGES=4: assert Rst with count_valid=1 in PRESENT -> count_valid=0, busy=0, count_out=0x000 immediately, without waiting for a clock edge.
- Legal decode, STAGES=4, stage codes {3:000_111, 2:110_101, 1:100_001, 0:101_111}, snap_req at edge k -> count_valid after edge k+4, count_out=12'o0637, code_err=0.
- Backpressure: hold rd_ready=0 for 10 cycles with count_valid=1 -> count_out stable and count_valid=1 throughout. Raise rd_ready -> count_valid=0 next cycle and busy=0.
- Ignored request: pulse snap_req during DECODE with changed inputs -> the presented count reflects only the first capture.
- Illegal code (DECODE_ERR_EN): stage 2 = 111_000, stage 1 = 011_011, others legal -> stages 1 and 2 both decode to 0, code_err=1, err_stage=1. The next clean snapshot gives code_err=0.
- Abort: Rst pulse during DECODE at index 2, then snap_req with all stages at 000_100 -> count_out=12'o5555. No stale digits and no premature count_valid.

Source files
------------

// File: rtl/lfsr_count_decoder.sv
// lfsr_count_decoder: snapshots all LFSR counter stages and decodes them to a binary count, one stage per clock.
// Optional illegal-code reporting is enabled by defining DECODE_ERR_EN.
module lfsr_count_decoder #(
    parameter int STAGES = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                snap_req,
    input  logic [3*STAGES-1:0] Q_in,
    input  logic [3*STAGES-1:0] S_in,
    output logic                busy,
    output logic [3*STAGES-1:0] count_out,
    output logic                count_valid,
    input  logic                rd_ready,
    output logic                code_err,
    output logic [3:0]          err_stage
);
    localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
    typedef enum logic [1:0] {IDLE, DECODE, PRESENT} state_t;
    state_t state, state_nx;
    logic [3*STAGES-1:0] q_cap, s_cap;
    logic [IW-1:0] idx;
    logic [5:0] code;
    logic last;
    function automatic logic [2:0] digit(input logic [5:0] c);
        case (c)
            6'b100_011: return 3'd1;
            6'b000_110: return 3'd2;
            6'b100_001: return 3'd3;
            6'b000_010: return 3'd4;
            6'b000_100: return 3'd5;
            6'b110_101: return 3'd6;
            6'b101_111: return 3'd7;
            default:    return 3'd0;
        endcase
    endfunction
    assign code = {s_cap[3*idx +: 3], q_cap[3*idx +: 3]};
    assign last = idx == IW'(STAGES - 1);
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = state == IDLE   ? (snap_req ? DECODE : IDLE) :
                   state == DECODE ? (last ? PRESENT : DECODE) :
                                     (rd_ready ? IDLE : PRESENT);
    always_comb begin
        busy = state != IDLE;
        count_valid = state == PRESENT;
    end
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            q_cap <= '0;
            s_cap <= '0;
            idx <= '0;
            count_out <= '0;
        end else if (state == IDLE && snap_req) begin
            q_cap <= Q_in;
            s_cap <= S_in;
            idx <= '0;
        end else if (state == DECODE) begin
            count_out[3*idx +: 3] <= digit(code);
            idx <= last ? '0 : idx + 1'b1;
        end
`ifdef DECODE_ERR_EN
    function automatic logic legal(input logic [5:0] c);
        case (c)
            6'b000_111, 6'b100_011, 6'b000_110, 6'b100_001,
            6'b000_010, 6'b000_100, 6'b110_101, 6'b101_111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    // Only the first offending stage is latched; later ones leave err_stage untouched.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            code_err <= 1'b0;
            err_stage <= '0;
        end else if (state == IDLE && snap_req) begin
            code_err <= 1'b0;
            err_stage <= '0;
        end else if (state == DECODE && !legal(code) && !code_err) begin
            code_err <= 1'b1;
            err_stage <= 4'(idx);
        end
`else
    assign code_err = 1'b0;
    assign err_stage = '0;
`endif
endmodule

// File: tb/tb_lfsr_count_decoder.sv
// tb_lfsr_count_decoder: directed and randomized snapshots checked against a table-lookup reference model.
module tb_lfsr_count_decoder;
    localparam int ST = 4;
    localparam int W = 3 * ST;
    logic Clk = 1'b0, Rst = 1'b1, snap_req = 1'b0, rd_ready = 1'b0;
    logic [W-1:0] Q_in = '0, S_in = '0;
    logic busy, count_valid, code_err;
    logic [W-1:0] count_out;
    logic [3:0] err_stage;
    int checks = 0, errors = 0;
    logic [5:0] tbl [8] = '{6'b000111, 6'b100011, 6'b000110, 6'b100001,
                            6'b000010, 6'b000100, 6'b110101, 6'b101111};
    logic [5:0] code [ST];
    logic [W-1:0] exp_count = '0;

    lfsr_count_decoder #(.STAGES(ST)) dut (
        .Clk(Clk), .Rst(Rst), .snap_req(snap_req), .Q_in(Q_in), .S_in(S_in),
        .busy(busy), .count_out(count_out), .count_valid(count_valid),
        .rd_ready(rd_ready), .code_err(code_err), .err_stage(err_stage)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Digit is the position of the code in the table; -1 marks an illegal code.
    function automatic int lookup(input logic [5:0] c);
        for (int i = 0; i < 8; i++) if (tbl[i] == c) return i;
        return -1;
    endfunction

    task automatic drive_codes();
        for (int i = 0; i < ST; i++) begin
            Q_in[3*i +: 3] = code[i][2:0];
            S_in[3*i +: 3] = code[i][5:3];
        end
    endtask

    task automatic rand_codes(input bit allow_bad);
        for (int i = 0; i < ST; i++)
            code[i] = (allow_bad && $urandom_range(0, 3) == 0) ? 6'($urandom) : tbl[$urandom_range(0, 7)];
    endtask

    task automatic snap(input bit ign);
        int first = -1;
        drive_codes();
        snap_req = 1'b1;
        @(posedge Clk); #1;
        snap_req = 1'b0;
        Q_in = W'($urandom);
        S_in = W'($urandom);
        for (int i = 0; i < ST; i++) begin
            chk("busy_decode", 32'(busy), 32'd1);
            chk("valid_decode", 32'(count_valid), 32'd0);
            snap_req = ign && i == 1;
            rd_ready = 1'($urandom);
            @(posedge Clk); #1;
            if (lookup(code[i]) < 0 && first < 0) first = i;
            exp_count[3*i +: 3] = lookup(code[i]) < 0 ? 3'd0 : 3'(lookup(code[i]));
            chk("digit_write", 32'(count_out), 32'(exp_count));
        end
        snap_req = 1'b0;
        rd_ready = 1'b0;
        chk("valid_rise", 32'(count_valid), 32'd1);
        chk("busy_present", 32'(busy), 32'd1);
`ifdef DECODE_ERR_EN
        chk("code_err", 32'(code_err), first >= 0 ? 32'd1 : 32'd0);
        chk("err_stage", 32'(err_stage), first >= 0 ? 32'(first) : 32'd0);
`else
        chk("code_err", 32'(code_err), 32'd0);
        chk("err_stage", 32'(err_stage), 32'd0);
`endif
    endtask

    task automatic ack(input int hold, input bit snap_same);
        repeat (hold) begin
            @(posedge Clk); #1;
            chk("hold_valid", 32'(count_valid), 32'd1);
            chk("hold_count", 32'(count_out), 32'(exp_count));
        end
        rd_ready = 1'b1;
        snap_req = snap_same;
        @(posedge Clk); #1;
        rd_ready = 1'b0;
        snap_req = 1'b0;
        chk("ack_valid", 32'(count_valid), 32'd0);
        chk("ack_busy", 32'(busy), 32'd0);
        chk("ack_count", 32'(count_out), 32'(exp_count));
    endtask

    task automatic reset_pulse();
        Rst = 1'b1;
        #1;
        exp_count = '0;
        chk("rst_valid", 32'(count_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_err", 32'(code_err), 32'd0);
        chk("rst_stage", 32'(err_stage), 32'd0);
        #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(count_valid), 32'd0);
    endtask

    initial begin
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_valid", 32'(count_valid), 32'd0);
        chk("init_count", 32'(count_out), 32'd0);
        #12;
        Rst = 1'b0;
        @(posedge Clk); #1;
        // Legal decode with backpressure and a request on the handshake edge.
        code[0] = 6'b101111; code[1] = 6'b100001; code[2] = 6'b110101; code[3] = 6'b000111;
        snap(1'b0);
        chk("legal_0637", 32'(count_out), 32'(12'o0637));
        ack(10, 1'b1);
        // Request during decode must be ignored.
        rand_codes(1'b0);
        snap(1'b1);
        ack(0, 1'b0);
        // Illegal codes in stages 1 and 2, then a clean snapshot.
        code[0] = tbl[3]; code[1] = 6'b011011; code[2] = 6'b111000; code[3] = tbl[5];
        snap(1'b0);
        chk("illegal_digits", 32'(count_out[8:3]), 32'd0);
        ack(0, 1'b0);
        rand_codes(1'b0);
        snap(1'b0);
        ack(1, 1'b0);
        // Async reset while presenting.
        rand_codes(1'b1);
        snap(1'b0);
        reset_pulse();
        // Async reset mid-decode at index 2, then a full snapshot of fives.
        rand_codes(1'b0);
        drive_codes();
        snap_req = 1'b1;
        @(posedge Clk); #1;
        snap_req = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end
        chk("abort_valid", 32'(count_valid), 32'd0);
        reset_pulse();
        for (int i = 0; i < ST; i++) code[i] = 6'b000100;
        snap(1'b0);
        chk("fives", 32'(count_out), 32'(12'o5555));
        ack(0, 1'b0);
        for (int n = 0; n < 30; n++) begin
            rand_codes(1'b1);
            snap(1'($urandom_range(0, 1)));
            ack($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
